signal_debouncer: RTL and testbench

//   Conditions a raw, asynchronous, possibly bouncing level into a clean, single-clock-domain level.

---
 rtl/signal_debouncer.sv | 128 ++++++++++++
 tb/tb_signal_debouncer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/signal_debouncer.sv
// signal_debouncer: two-flop synchronizer feeding a counter-based confirm FSM.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronized
// samples; rejected candidate transitions are tallied in a saturating counter.
module signal_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  input  logic                en,
  input  logic                glitch_clr,
  output logic                clean_out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'b00,
    CONFIRM_HI = 2'b01,
    STABLE_HI  = 2'b10,
    CONFIRM_LO = 2'b11
  } state_t;

  logic          sync1, sync2;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          clean_nxt;
  logic          glitch_ev;

  // Two-flop synchronizer; runs regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // FSM state, confirm counter and registered clean level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STABLE_LO;
      cnt       <= '0;
      clean_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      clean_out <= clean_nxt;
    end
  end

  // Next-state logic; with en low everything holds and no glitch is flagged
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean_out;
    glitch_ev = 1'b0;
    if (en) begin
      case (state)
        STABLE_LO: begin
          if (sync2) begin
            state_nxt = CONFIRM_HI;
            cnt_nxt   = CW'(1);
          end
        end
        CONFIRM_HI: begin
          if (!sync2) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
            glitch_ev = 1'b1;
          end else if (cnt == LAST) begin
            state_nxt = STABLE_HI;
            clean_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STABLE_HI: begin
          if (!sync2) begin
            state_nxt = CONFIRM_LO;
            cnt_nxt   = CW'(1);
          end
        end
        CONFIRM_LO: begin
          if (sync2) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
            glitch_ev = 1'b1;
          end else if (cnt == LAST) begin
            state_nxt = STABLE_LO;
            clean_nxt = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Saturating glitch counter; clear takes priority over a coincident event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_ev && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end

  // Busy while a candidate transition is being confirmed
  always_comb begin
    busy = (state == CONFIRM_HI) || (state == CONFIRM_LO);
  end

endmodule

// File: tb/tb_signal_debouncer.sv
// tb_signal_debouncer: table-driven vectors for clean steps and a bounce,
// plus directed sequences for settle-after-bounce, saturation/clear,
// enable freeze and asynchronous reset mid-confirm.
module tb_signal_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_in = 1'b0;
  logic       en = 1'b1;
  logic       glitch_clr = 1'b0;
  logic       clean_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic       raw;
    logic       clean;
    logic       busy;
    logic [7:0] glitch;
  } vec_t;

  vec_t vecs[$];

  signal_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .GLITCH_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw_in),
    .en(en),
    .glitch_clr(glitch_clr),
    .clean_out(clean_out),
    .busy(busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic c, input logic b, input int g);
    check({name, ".clean"}, int'(clean_out), int'(c));
    check({name, ".busy"}, int'(busy), int'(b));
    check({name, ".glitch"}, int'(glitch_cnt), g);
  endtask

  // One-sample pulse; the glitch is counted on the last of the four edges
  task automatic pulse();
    raw_in = 1'b1;
    step();
    raw_in = 1'b0;
    steps(3);
  endtask

  initial begin
    // clean rise from reset idle
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, (i >= 5), (i >= 2 && i <= 4), 8'd0});
    // clean fall
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, (i <= 4), (i >= 2 && i <= 4), 8'd0});
    // three-cycle bounce, rejected
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1});

    // reset values
    steps(2);
    check_all("reset", 1'b0, 1'b0, 0);
    rst = 1'b0;

    // table: each record is driven before an edge and checked after it
    foreach (vecs[i]) begin
      raw_in = vecs[i].raw;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].clean, vecs[i].busy, int'(vecs[i].glitch));
    end

    // bounce then settle: 1,0,1,1,... ; final rise before edge 2
    raw_in = 1'b1; step();
    raw_in = 1'b0; step();
    raw_in = 1'b1;
    steps(5);
    check_all("settle.pre", 1'b0, 1'b1, 2);
    step();
    check_all("settle.rise", 1'b1, 1'b0, 2);
    raw_in = 1'b0;
    steps(8);
    check_all("settle.low", 1'b0, 1'b0, 2);

    // saturation
    for (int i = 0; i < 260; i++) pulse();
    check_all("sat", 1'b0, 1'b0, 255);

    // clear coincident with a glitch event
    raw_in = 1'b1; step();
    raw_in = 1'b0; steps(2);
    check_all("clr.pre", 1'b0, 1'b1, 255);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    check_all("clr", 1'b0, 1'b0, 0);
    pulse();
    check("glitch.after_clr", int'(glitch_cnt), 1);

    // enable freeze with cnt=2
    raw_in = 1'b1;
    steps(4);
    en = 1'b0;
    steps(10);
    check_all("freeze", 1'b0, 1'b1, 1);
    en = 1'b1;
    step();
    check_all("resume1", 1'b0, 1'b1, 1);
    step();
    check_all("resume2", 1'b1, 1'b0, 1);
    raw_in = 1'b0;
    steps(8);
    check_all("freeze.low", 1'b0, 1'b0, 1);

    // async reset mid-CONFIRM_HI
    raw_in = 1'b1;
    steps(3);
    check_all("rst.pre", 1'b0, 1'b1, 1);
    #3 rst = 1'b1;
    #1;
    check_all("rst.async", 1'b0, 1'b0, 0);
    #1 rst = 1'b0;
    steps(5);
    check_all("rst.post_pre", 1'b0, 1'b1, 0);
    step();
    check_all("rst.post_rise", 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
